l1_dcache: RTL and testbench

// Direct-mapped, write-back, write-allocate L1 data cache. Responder for the MEM stage data port.

---
 rtl/l1_dcache_if.sv | 40 ++++
 rtl/l1_dcache.sv | 158 +++++++++++++++
 tb/tb_l1_dcache.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_if.sv
// CPU data-port and physical-memory line-port bundles for l1_dcache.
// The cache is the slave on the CPU side and the master on the pmem side.
interface l1_dcache_if;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

interface l1_dcache_pmem_if;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Define DCACHE_PERF_EN to build the hit/miss counters; otherwise they read as zero.
module l1_dcache #(
   parameter int S_INDEX = 3
) (
   input  logic              clk,
   input  logic              rst,
   l1_dcache_if.slave        mem,
   l1_dcache_pmem_if.master  pmem,
   output logic [31:0]       perf_hits,
   output logic [31:0]       perf_misses
);
   localparam int SETS  = 2 ** S_INDEX;
   localparam int TAG_W = 32 - 5 - S_INDEX;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

   state_t state_reg, state_next;

   logic [SETS-1:0]    valid_reg;
   logic [SETS-1:0]    dirty_reg;
   logic [TAG_W-1:0]   tag_mem  [SETS];
   logic [255:0]       data_mem [SETS];
   logic [255:0]       line_reg;

   logic [S_INDEX-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [2:0]         word_sel;
   logic               req;
   logic               hit;
   logic               fill_done;
   logic               write_hit;
   logic [31:0]        cur_word;
   logic [31:0]        merged_word;
   logic [255:0]       merged_line;

   assign idx       = mem.mem_address[5 +: S_INDEX];
   assign tag       = mem.mem_address[31 -: TAG_W];
   assign word_sel  = mem.mem_address[4:2];
   assign req       = mem.mem_read | mem.mem_write;
   assign hit       = valid_reg[idx] && (tag_mem[idx] == tag);
   assign cur_word  = line_reg[{word_sel, 5'b0} +: 32];
   assign fill_done = (state_reg == ALLOCATE) && pmem.pmem_resp;
   assign write_hit = (state_reg == COMPARE) && hit && mem.mem_write && (|mem.mem_byte_enable);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = mem.mem_byte_enable[gi] ? mem.mem_wdata[gi*8 +: 8]
                                                               : cur_word[gi*8 +: 8];
   end

   always_comb begin
      merged_line = line_reg;
      merged_line[{word_sel, 5'b0} +: 32] = merged_word;
   end

   // Line storage with registered read; a completing fill bypasses into the
   // read register so the replay COMPARE sees the new line without a stall.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[idx] <= pmem.pmem_rdata;
         tag_mem[idx]  <= tag;
         line_reg      <= pmem.pmem_rdata;
      end else begin
         if (write_hit) begin
            data_mem[idx] <= merged_line;
         end
         line_reg <= data_mem[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         valid_reg <= '0;
         dirty_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (fill_done) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= 1'b0;
         end else if (write_hit) begin
            dirty_reg[idx] <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next        = state_reg;
      mem.mem_resp      = 1'b0;
      mem.mem_rdata     = '0;
      pmem.pmem_read    = 1'b0;
      pmem.pmem_write   = 1'b0;
      pmem.pmem_address = '0;
      pmem.pmem_wdata   = '0;
      case (state_reg)
         IDLE: begin
            if (req) state_next = COMPARE;
         end
         COMPARE: begin
            if (hit) begin
               mem.mem_resp  = 1'b1;
               mem.mem_rdata = cur_word;
               state_next    = IDLE;
            end else if (valid_reg[idx] && dirty_reg[idx]) begin
               state_next = WRITEBACK;
            end else begin
               state_next = ALLOCATE;
            end
         end
         WRITEBACK: begin
            pmem.pmem_write   = 1'b1;
            pmem.pmem_address = {tag_mem[idx], idx, 5'b0};
            pmem.pmem_wdata   = line_reg;
            if (pmem.pmem_resp) state_next = ALLOCATE;
         end
         ALLOCATE: begin
            pmem.pmem_read    = 1'b1;
            pmem.pmem_address = {mem.mem_address[31:5], 5'b0};
            if (pmem.pmem_resp) state_next = COMPARE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef DCACHE_PERF_EN
   logic [31:0] hits_reg;
   logic [31:0] misses_reg;
   logic        replay_reg;

   // The COMPARE that follows a fill is a replay and must not count as a hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hits_reg   <= '0;
         misses_reg <= '0;
         replay_reg <= 1'b0;
      end else begin
         if (fill_done) begin
            replay_reg <= 1'b1;
         end else if (state_reg == COMPARE) begin
            replay_reg <= 1'b0;
         end
         if (state_reg == COMPARE && hit && !replay_reg) begin
            hits_reg <= hits_reg + 32'd1;
         end
         if (state_reg == COMPARE && !hit) begin
            misses_reg <= misses_reg + 32'd1;
         end
      end
   end

   assign perf_hits   = hits_reg;
   assign perf_misses = misses_reg;
`else
   assign perf_hits   = '0;
   assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized scoreboard bench for l1_dcache against a flat word-memory view,
// a tag-only direct-mapped model and a backing line store.
`timescale 1ns/1ps
module tb_l1_dcache;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;

   always #5 clk = ~clk;

   l1_dcache_if      m ();
   l1_dcache_pmem_if p ();

   l1_dcache #(.S_INDEX(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem         (m),
      .pmem        (p),
      .perf_hits   (perf_hits),
      .perf_misses (perf_misses)
   );

   typedef struct packed {
      logic        is_read;
      logic [31:0] data;
      logic [31:0] issue;
      logic [31:0] lat;
      logic [31:0] addr;
   } resp_t;

   typedef struct packed {
      logic        is_write;
      logic [31:0] addr;
   } pm_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] cyc   = 0;

   resp_t sb_q[$];
   pm_t   pm_q[$];

   logic [255:0] backing [int unsigned];
   logic [31:0]  golden  [int unsigned];
   logic         m_valid [8];
   logic         m_dirty [8];
   int unsigned  m_line  [8];
   int           exp_hits   = 0;
   int           exp_misses = 0;
   int unsigned  pm_lat     = 1;
   logic         hold_pmem  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] gen_line(input int unsigned l);
      logic [255:0] v;
      for (int w = 0; w < 8; w++) begin
         v[w*32 +: 32] = (l * 32'h9E37_79B9) ^ (w * 32'h0101_0101) ^ 32'h5A5A_0000;
      end
      return v;
   endfunction

   function automatic logic [255:0] backing_line(input int unsigned l);
      if (backing.exists(l)) return backing[l];
      return gen_line(l);
   endfunction

   function automatic logic [31:0] view_word(input logic [31:0] a);
      logic [255:0] ln;
      int unsigned  w;
      if (golden.exists(a >> 2)) return golden[a >> 2];
      ln = backing_line(a >> 5);
      w  = int'(a[4:2]);
      return ln[w*32 +: 32];
   endfunction

   function automatic logic [255:0] view_line(input int unsigned l);
      logic [255:0] v;
      for (int w = 0; w < 8; w++) begin
         v[w*32 +: 32] = view_word((l << 5) + w * 4);
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
         m_line[s]  = 0;
      end
      golden.delete();
      sb_q.delete();
      pm_q.delete();
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic check_perf(input string tag);
      int eh;
      int em;
`ifdef DCACHE_PERF_EN
      eh = exp_hits;
      em = exp_misses;
`else
      eh = 0;
      em = 0;
`endif
      total++;
      if (perf_hits !== 32'(eh)) begin
         bad++;
         $display("FAIL perf_hits[%s] got=%0d want=%0d", tag, perf_hits, eh);
      end
      total++;
      if (perf_misses !== 32'(em)) begin
         bad++;
         $display("FAIL perf_misses[%s] got=%0d want=%0d", tag, perf_misses, em);
      end
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned set;
      int unsigned line;
      int unsigned lat;
      logic        hit;
      logic        is_write;
      logic [31:0] nw;
      resp_t       r;
      pm_t         t;
      int          n;
      is_write = wr;
      set      = (addr >> 5) & 7;
      line     = addr >> 5;
      pm_lat   = $urandom_range(1, 3);
      hit      = m_valid[set] && (m_line[set] == line);
      if (hit) begin
         lat = 1;
         exp_hits++;
      end else begin
         exp_misses++;
         if (m_valid[set] && m_dirty[set]) begin
            t.is_write = 1'b1;
            t.addr     = m_line[set] << 5;
            pm_q.push_back(t);
            lat = 2 + 2 * pm_lat;
         end else begin
            lat = 2 + pm_lat;
         end
         t.is_write = 1'b0;
         t.addr     = line << 5;
         pm_q.push_back(t);
         m_valid[set] = 1'b1;
         m_line[set]  = line;
         m_dirty[set] = 1'b0;
      end
      if (is_write && be != 4'b0000) begin
         nw = view_word(addr);
         for (int i = 0; i < 4; i++) begin
            if (be[i]) nw[i*8 +: 8] = wdata[i*8 +: 8];
         end
         golden[addr >> 2] = nw;
         m_dirty[set] = 1'b1;
      end
      r.is_read = !is_write;
      r.data    = view_word(addr);
      r.issue   = cyc;
      r.lat     = lat;
      r.addr    = addr;
      sb_q.push_back(r);

      m.mem_read        = rd;
      m.mem_write       = wr;
      m.mem_byte_enable = be;
      m.mem_address     = addr;
      m.mem_wdata       = wdata;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!m.mem_resp && n < 200);
      if (!m.mem_resp) begin
         total++;
         bad++;
         $display("FAIL req_timeout addr=%h got mem_resp=0 want mem_resp=1", addr);
      end
      @(posedge clk); #1;
      m.mem_read  = 1'b0;
      m.mem_write = 1'b0;
      check_perf("req");
   endtask

   // Scoreboard monitor: every mem_resp consumes one expectation.
   always @(negedge clk) begin
      resp_t r;
      if (m.mem_resp === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL spurious_resp addr=%h got mem_resp=1 want no response", m.mem_address);
         end else begin
            r = sb_q.pop_front();
            if (cyc - r.issue != r.lat) begin
               bad++;
               $display("FAIL latency addr=%h got=%0d want=%0d", r.addr, cyc - r.issue, r.lat);
            end
            if (r.is_read) begin
               total++;
               if (m.mem_rdata !== r.data) begin
                  bad++;
                  $display("FAIL rdata addr=%h got=%h want=%h", r.addr, m.mem_rdata, r.data);
               end
            end
         end
      end
   end

   // Physical memory responder.
   initial begin
      int          cnt;
      pm_t         t;
      logic [255:0] exp_line;
      cnt = 0;
      p.pmem_resp  = 1'b0;
      p.pmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         p.pmem_resp = 1'b0;
         if (rst || !(p.pmem_read || p.pmem_write)) begin
            cnt = 0;
         end else if (!hold_pmem) begin
            cnt++;
            if (cnt >= int'(pm_lat)) begin
               cnt = 0;
               total++;
               if (p.pmem_read && p.pmem_write) begin
                  bad++;
                  $display("FAIL pmem_both got read=1 write=1 want exactly one");
               end
               total++;
               if (pm_q.size() == 0) begin
                  bad++;
                  $display("FAIL pmem_unexpected got wr=%b addr=%h want no pmem access",
                           p.pmem_write, p.pmem_address);
               end else begin
                  t = pm_q.pop_front();
                  if (t.is_write !== p.pmem_write || t.addr !== p.pmem_address) begin
                     bad++;
                     $display("FAIL pmem_txn got wr=%b addr=%h want wr=%b addr=%h",
                              p.pmem_write, p.pmem_address, t.is_write, t.addr);
                  end
               end
               if (p.pmem_write) begin
                  exp_line = view_line(p.pmem_address >> 5);
                  total++;
                  if (p.pmem_wdata !== exp_line) begin
                     bad++;
                     $display("FAIL wb_data addr=%h got=%h want=%h", p.pmem_address, p.pmem_wdata, exp_line);
                  end
                  backing[p.pmem_address >> 5] = p.pmem_wdata;
               end else begin
                  p.pmem_rdata = backing_line(p.pmem_address >> 5);
               end
               p.pmem_resp = 1'b1;
            end
         end
      end
   end

   initial begin
      logic [255:0] l2;
      logic [23:0]  tag_pool [4];
      logic [31:0]  addr;
      int           op;
      int           n;
      logic [3:0]   be;
      tag_pool[0] = 24'h000000;
      tag_pool[1] = 24'h000001;
      tag_pool[2] = 24'h000002;
      tag_pool[3] = 24'hFFFFFF;

      rst = 1'b1;
      m.mem_read = 1'b0; m.mem_write = 1'b0; m.mem_byte_enable = '0;
      m.mem_address = '0; m.mem_wdata = '0;
      model_reset();
      l2 = gen_line(2);
      l2[2*32 +: 32] = 32'hDEAD_BEEF;
      backing[2] = l2;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (m.mem_resp !== 1'b0 || m.mem_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_mem got resp=%b rdata=%h want resp=0 rdata=0", m.mem_resp, m.mem_rdata);
      end
      total++;
      if (p.pmem_read !== 1'b0 || p.pmem_write !== 1'b0 || p.pmem_address !== 32'h0 || p.pmem_wdata !== 256'h0) begin
         bad++;
         $display("FAIL reset_pmem got rd=%b wr=%b addr=%h wdata_nz=%b want all zero",
                  p.pmem_read, p.pmem_write, p.pmem_address, |p.pmem_wdata);
      end
      check_perf("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0);
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0048, 32'h0);
      do_req(1'b0, 1'b1, 4'b0101, 32'h0000_0048, 32'h1122_3344);
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0048, 32'h0);
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0140, 32'h0);
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0048, 32'h0);
      do_req(1'b0, 1'b1, 4'b0000, 32'h0000_0044, 32'hFFFF_FFFF);
      do_req(1'b1, 1'b1, 4'b1111, 32'h0000_005C, 32'hCAFE_F00D);

      for (int i = 0; i < 250; i++) begin
         addr = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 9);
         be = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         if (op < 5)      do_req(1'b1, 1'b0, be, addr, $urandom);
         else if (op < 9) do_req(1'b0, 1'b1, be, addr, $urandom);
         else             do_req(1'b1, 1'b1, be, addr, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end

      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_perf("rst1");
      hold_pmem = 1'b1;
      m.mem_read = 1'b1; m.mem_write = 1'b0; m.mem_address = 32'h0000_0040;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!p.pmem_read && n < 20);
      total++;
      if (p.pmem_read !== 1'b1) begin
         bad++;
         $display("FAIL alloc_reach got pmem_read=%b want 1", p.pmem_read);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (p.pmem_read !== 1'b0 || p.pmem_write !== 1'b0) begin
         bad++;
         $display("FAIL rst_drop got rd=%b wr=%b want rd=0 wr=0", p.pmem_read, p.pmem_write);
      end
      m.mem_read = 1'b0;
      model_reset();
      @(posedge clk); #1;
      hold_pmem = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check_perf("rst2");
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0);
      do_req(1'b1, 1'b0, 4'b0000, 32'h0000_0040, 32'h0);

      repeat (4) @(posedge clk);
      #1;
      total++;
      if (sb_q.size() != 0 || pm_q.size() != 0) begin
         bad++;
         $display("FAIL leftover got sb=%0d pm=%0d want sb=0 pm=0", sb_q.size(), pm_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
